// File: rtl/ysyx_041514_icache_refill_pkg.sv
// Shared constants, state encoding and helpers for the icache miss-refill engine.
// Optional perf counters are enabled with YSYX_041514_ICACHE_REFILL_PERF_EN.
package ysyx_041514_icache_refill_pkg;

    localparam int IDX_LEN = 6;   // set index, paddr[11:6]
    localparam int BLK_LEN = 6;   // byte offset inside a 64B line
    localparam int TAG_LEN = 20;  // paddr[31:12]
    localparam int ADDR_W  = 32;
    localparam int BEAT_W  = 64;
    localparam int LINE_W  = 128; // one array bank row

    // AXI constants for a full-line INCR burst of 8 x 8B beats
    localparam logic [7:0] AXI_LEN_LINE = 8'd7;
    localparam logic [2:0] SIZE_8B      = 3'b011;
    localparam logic [1:0] BURST_INCR   = 2'b01;
    localparam logic [1:0] RESP_OKAY    = 2'b00;
    localparam logic [2:0] LAST_BEAT    = 3'd7;

    // Clears the in-line offset so the burst starts on the line boundary
    localparam logic [ADDR_W-1:0] LINE_MASK = {{(ADDR_W-BLK_LEN){1'b1}}, {BLK_LEN{1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_AR   = 2'b01,
        ST_R    = 2'b10,
        ST_DONE = 2'b11
    } state_e;

    // Selects the 64b half of a bank row that an even/odd beat lands in
    function automatic logic [LINE_W-1:0] half_mask(input logic upper);
        logic [LINE_W-1:0] m;
        if (upper) begin
            m = {{BEAT_W{1'b1}}, {BEAT_W{1'b0}}};
        end else begin
            m = {{BEAT_W{1'b0}}, {BEAT_W{1'b1}}};
        end
        return m;
    endfunction

    // 64-bit increment that sticks at all-ones instead of wrapping
    function automatic logic [63:0] sat_inc64(input logic [63:0] v);
        logic [63:0] r;
        if (v == {64{1'b1}}) begin
            r = v;
        end else begin
            r = v + 64'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/ysyx_041514_icache_refill_if.sv
// AXI4 read-address / read-data channel bundle between the refill engine
// (master) and the memory interconnect (slave).
interface ysyx_041514_icache_refill_if;
    import ysyx_041514_icache_refill_pkg::*;

    logic              arvalid;
    logic              arready;
    logic [ADDR_W-1:0] araddr;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic              rvalid;
    logic              rready;
    logic [BEAT_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rlast;

    modport master (
        output arvalid, araddr, arlen, arsize, arburst, rready,
        input  arready, rvalid, rdata, rresp, rlast
    );

    modport slave (
        input  arvalid, araddr, arlen, arsize, arburst, rready,
        output arready, rvalid, rdata, rresp, rlast
    );

endinterface

// File: rtl/ysyx_041514_icache_refill_perf_cnt.sv
// Saturating miss / busy-cycle counter pair for the refill engine.
// Only compiled when YSYX_041514_ICACHE_REFILL_PERF_EN is defined.
`ifdef YSYX_041514_ICACHE_REFILL_PERF_EN
module ysyx_041514_icache_perf_cnt
    import ysyx_041514_icache_refill_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        miss_inc_i,
    input  logic        cyc_inc_i,
    output logic [63:0] miss_cnt_o,
    output logic [63:0] cyc_cnt_o
);

    logic [63:0] miss_q;
    logic [63:0] cyc_q;

    // Count accepted misses and non-idle cycles, holding at all-ones
    always_ff @(posedge clk) begin
        if (rst) begin
            miss_q <= 64'd0;
            cyc_q  <= 64'd0;
        end else begin
            if (miss_inc_i) begin
                miss_q <= sat_inc64(miss_q);
            end
            if (cyc_inc_i) begin
                cyc_q <= sat_inc64(cyc_q);
            end
        end
    end

    assign miss_cnt_o = miss_q;
    assign cyc_cnt_o  = cyc_q;

endmodule
`endif

// File: rtl/ysyx_041514_icache_refill.sv
// icache miss-refill engine: one line miss -> one 8-beat AXI INCR burst,
// each beat written into the banked data array one cycle after its handshake,
// then a single tag/valid write (suppressed if any beat was bad).
// YSYX_041514_ICACHE_REFILL_PERF_EN adds saturating perf counters.
module ysyx_041514_icache_refill
    import ysyx_041514_icache_refill_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                miss_req_i,
    input  logic [ADDR_W-1:0]   miss_addr_i,
    output logic                miss_ready_o,
    output logic                refill_done_o,
    output logic                refill_err_o,
    ysyx_041514_icache_refill_if.master axi,
    output logic [IDX_LEN-1:0]  icache_index_o,
    output logic [LINE_W-1:0]   icache_line_wdata_o,
    output logic [LINE_W-1:0]   icache_wmask_o,
    output logic [2:0]          burst_count_o,
    output logic                icache_wen_o,
    output logic                tag_wen_o,
    output logic [TAG_LEN-1:0]  tag_o
`ifdef YSYX_041514_ICACHE_REFILL_PERF_EN
    ,
    output logic [63:0]         perf_miss_cnt_o,
    output logic [63:0]         perf_refill_cyc_o
`endif
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q;      // line-aligned miss address
    logic [BEAT_W-1:0] beat_q;      // last received beat, written next cycle
    logic [2:0]        rcv_cnt_q;   // beats received so far in this burst
    logic [2:0]        wr_cnt_q;    // beat number of the array write in flight
    logic              wen_q;
    logic              last_q;      // final beat taken, waiting for its write
    logic              err_q;       // sticky error for the current refill

    logic accept_s;
    logic r_hs_s;
    logic beat_exit_s;
    logic beat_err_s;

    // Handshake and per-beat decode
    always_comb begin
        accept_s    = (state_q == ST_IDLE) && miss_req_i;
        r_hs_s      = (state_q == ST_R) && !last_q && axi.rvalid;
        beat_exit_s = axi.rlast || (rcv_cnt_q == LAST_BEAT);
        // Error on bad response, rlast too early, or rlast missing on beat 7
        beat_err_s  = (axi.rresp != RESP_OKAY) || (axi.rlast != (rcv_cnt_q == LAST_BEAT));
    end

    // Next-state logic; R leaves only once the final beat has been written
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (miss_req_i) begin
                    state_d = ST_AR;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_AR: begin
                if (axi.arready) begin
                    state_d = ST_R;
                end else begin
                    state_d = ST_AR;
                end
            end
            ST_R: begin
                if (last_q) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_R;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Address latch, beat capture, counters and sticky error
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q    <= {ADDR_W{1'b0}};
            beat_q    <= {BEAT_W{1'b0}};
            rcv_cnt_q <= 3'd0;
            wr_cnt_q  <= 3'd0;
            wen_q     <= 1'b0;
            last_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            wen_q <= r_hs_s;
            if (accept_s) begin
                addr_q <= miss_addr_i & LINE_MASK;
                err_q  <= 1'b0;
            end
            if (r_hs_s) begin
                beat_q <= axi.rdata;
                if (beat_exit_s) begin
                    rcv_cnt_q <= 3'd0;
                    last_q    <= 1'b1;
                end else begin
                    rcv_cnt_q <= rcv_cnt_q + 3'd1;
                end
                if (beat_err_s) begin
                    err_q <= 1'b1;
                end
            end
            if (wen_q) begin
                wr_cnt_q <= wr_cnt_q + 3'd1;
            end
            // An early exit leaves the write count mid-line; restart it here
            if (state_q == ST_DONE) begin
                last_q   <= 1'b0;
                wr_cnt_q <= 3'd0;
            end
        end
    end

    assign miss_ready_o  = (state_q == ST_IDLE);
    assign refill_done_o = (state_q == ST_DONE);
    assign refill_err_o  = (state_q == ST_DONE) && err_q;
    assign tag_wen_o     = (state_q == ST_DONE) && !err_q;

    assign axi.arvalid = (state_q == ST_AR);
    assign axi.araddr  = addr_q;
    assign axi.arlen   = AXI_LEN_LINE;
    assign axi.arsize  = SIZE_8B;
    assign axi.arburst = BURST_INCR;
    assign axi.rready  = (state_q == ST_R) && !last_q;

    // Each 64b beat is duplicated; the mask picks the half by beat parity
    assign icache_index_o      = addr_q[BLK_LEN +: IDX_LEN];
    assign tag_o               = addr_q[ADDR_W-1 -: TAG_LEN];
    assign icache_line_wdata_o = {beat_q, beat_q};
    assign icache_wmask_o      = wen_q ? half_mask(wr_cnt_q[0]) : {LINE_W{1'b0}};
    assign burst_count_o       = wr_cnt_q;
    assign icache_wen_o        = wen_q;

`ifdef YSYX_041514_ICACHE_REFILL_PERF_EN
    ysyx_041514_icache_perf_cnt u_perf_cnt (
        .clk        (clk),
        .rst        (rst),
        .miss_inc_i (accept_s),
        .cyc_inc_i  (state_q != ST_IDLE),
        .miss_cnt_o (perf_miss_cnt_o),
        .cyc_cnt_o  (perf_refill_cyc_o)
    );
`endif

endmodule
